// File: rtl/knn_mem_pkg.sv
// Shared constants and types for the partialKnn local-buffer streamer.
// Geometry of the URAM buffer and the read-return path lives here.
package knn_mem_pkg;

  localparam int unsigned DataWidth    = 256;
  localparam int unsigned AddressRange = 2048;
  localparam int unsigned AddressWidth = $clog2(AddressRange);
  localparam int unsigned LenWidth     = AddressWidth + 1;
  localparam int unsigned ReadLatency  = 2;
  localparam int unsigned FifoDepth    = 4;
  localparam int unsigned CountWidth   = $clog2(FifoDepth + 1);
  // Wide enough to hold a full pipe plus a full FIFO.
  localparam int unsigned CreditWidth  = CountWidth + 1;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain
  } state_e;

  typedef struct packed {
    logic                    write;
    logic [AddressWidth-1:0] base;
    logic [LenWidth-1:0]     len;
  } cmd_t;

endpackage

// File: rtl/knn_local_sp_mem_streamer_if.sv
// Bundle of command, load/scan streams and single-port memory signals.
// master is the streamer's view, slave the surrounding kernel's view.
interface knn_local_sp_mem_streamer_if;
  import knn_mem_pkg::*;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [AddressWidth-1:0] cmd_base;
  logic [LenWidth-1:0]     cmd_len;
  logic                    wr_data_valid;
  logic                    wr_data_ready;
  logic [DataWidth-1:0]    wr_data;
  logic                    rd_data_valid;
  logic                    rd_data_ready;
  logic [DataWidth-1:0]    rd_data;
  logic                    rd_data_last;
  logic                    done;
  logic [AddressWidth-1:0] address0;
  logic                    ce0;
  logic                    we0;
  logic [DataWidth-1:0]    d0;
  logic [DataWidth-1:0]    q0;

  modport master (
    input  cmd_valid, cmd_write, cmd_base, cmd_len, wr_data_valid, wr_data, rd_data_ready, q0,
    output cmd_ready, wr_data_ready, rd_data_valid, rd_data, rd_data_last, done,
    output address0, ce0, we0, d0
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_base, cmd_len, wr_data_valid, wr_data, rd_data_ready, q0,
    input  cmd_ready, wr_data_ready, rd_data_valid, rd_data, rd_data_last, done,
    input  address0, ce0, we0, d0
  );

endinterface

// File: rtl/knn_rd_return_fifo.sv
// Show-ahead FIFO that catches read returns; head is valid whenever not empty.
module knn_rd_return_fifo import knn_mem_pkg::*; #(
  parameter int unsigned Depth = FifoDepth,
  parameter int unsigned Width = DataWidth + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [Width-1:0]               push_data,
  input  logic                           pop,
  output logic                           empty,
  output logic [Width-1:0]               head,
  output logic [$clog2(Depth+1)-1:0]     count
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;

  function automatic logic [PtrWidth-1:0] bump(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + CntWidth'(1);
      else if (!push && pop) count <= count - CntWidth'(1);
    end
  end

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/knn_local_sp_mem_streamer.sv
// Initiator for the partialKnn single-port local buffer: loads a stream into
// consecutive words and scans them back out under credit-based flow control.
module knn_local_sp_mem_streamer import knn_mem_pkg::*; (
  input logic                          clk,
  input logic                          reset,
  knn_local_sp_mem_streamer_if.master  bus
);

  state_e                  state;
  cmd_t                    cmd;
  logic [AddressWidth-1:0] ptr;
  logic [LenWidth-1:0]     remaining;
  logic [ReadLatency-1:0]  pipe_valid;
  logic [ReadLatency-1:0]  pipe_last;
  logic                    done_q;
  logic [CreditWidth-1:0]  credit_used;
  logic                    wr_fire;
  logic                    issue;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic [DataWidth:0]      fifo_head;
  logic [CountWidth-1:0]   fifo_count;

  assign cmd = '{write: bus.cmd_write, base: bus.cmd_base, len: bus.cmd_len};

  // Reads in the latency pipe plus words parked in the FIFO must fit the FIFO,
  // so every issued read has a guaranteed slot whatever rd_data_ready does.
  always_comb begin
    credit_used = CreditWidth'(fifo_count);
    for (int i = 0; i < ReadLatency; i++) begin
      credit_used = credit_used + CreditWidth'(pipe_valid[i]);
    end
  end

  always_comb begin
    wr_fire           = (state == StWrite) && bus.wr_data_valid;
    issue             = (state == StRead) && (credit_used < CreditWidth'(FifoDepth));
    fifo_pop          = !fifo_empty && bus.rd_data_ready;
    bus.cmd_ready     = (state == StIdle);
    bus.wr_data_ready = (state == StWrite);
    bus.ce0           = wr_fire || issue;
    bus.we0           = wr_fire;
    bus.address0      = ptr;
    bus.d0            = (state == StWrite) ? bus.wr_data : '0;
    bus.rd_data_valid = !fifo_empty;
    bus.rd_data       = fifo_empty ? '0 : fifo_head[DataWidth-1:0];
    bus.rd_data_last  = !fifo_empty && fifo_head[DataWidth];
    bus.done          = done_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      ptr        <= '0;
      remaining  <= '0;
      pipe_valid <= '0;
      pipe_last  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      pipe_valid[0] <= issue;
      pipe_last[0]  <= issue && (remaining == LenWidth'(1));
      for (int i = 1; i < ReadLatency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
      unique case (state)
        StIdle: begin
          if (bus.cmd_valid) begin
            ptr       <= cmd.base;
            remaining <= cmd.len;
            if (cmd.len == '0)  state <= StDrain;
            else if (cmd.write) state <= StWrite;
            else                state <= StRead;
          end
        end
        StWrite, StRead: begin
          if (wr_fire || issue) begin
            ptr       <= ptr + AddressWidth'(1);
            remaining <= remaining - LenWidth'(1);
            if (remaining == LenWidth'(1)) state <= StDrain;
          end
        end
        StDrain: begin
          if (!(|pipe_valid) && fifo_empty) begin
            done_q <= 1'b1;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  knn_rd_return_fifo #(
    .Depth(FifoDepth),
    .Width(DataWidth + 1)
  ) u_rd_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pipe_valid[ReadLatency-1]),
    .push_data({pipe_last[ReadLatency-1], bus.q0}),
    .pop      (fifo_pop),
    .empty    (fifo_empty),
    .head     (fifo_head),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_knn_local_sp_mem_streamer.sv
// Randomised and directed bench for the local-buffer streamer, checked against
// a flat reference memory and address/word queues derived from the commands.
module tb_knn_local_sp_mem_streamer;
  import knn_mem_pkg::*;

  typedef logic [DataWidth:0] val_t;
  typedef logic [DataWidth-1:0] word_t;
  typedef struct {
    int    addr;
    word_t data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  knn_local_sp_mem_streamer_if bus ();

  knn_local_sp_mem_streamer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Memory model: plain array with a ReadLatency-deep output register chain.
  word_t mem [AddressRange];
  word_t q_pipe [ReadLatency];
  always @(posedge clk) begin
    if (bus.ce0 && bus.we0) mem[bus.address0] <= bus.d0;
    q_pipe[0] <= mem[bus.address0];
    for (int i = 1; i < ReadLatency; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign bus.q0 = q_pipe[ReadLatency-1];

  // Reference state.
  word_t ref_mem [AddressRange];
  wr_t   exp_wr[$];
  int    exp_rd_addr[$];
  val_t  exp_rd[$];
  int    n_issued = 0, n_popped = 0, stall_seen = 0, ce_count = 0;
  int    wr_cyc_log[$], wr_addr_log[$], rd_addr_log[$], rv_cyc_log[$];
  word_t rv_data_log[$];
  int    checks = 0, passes = 0;
  int    rdy_mode = 0;

  function automatic void check(input bit ok, input string name, input val_t act, input val_t req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endfunction

  always @(negedge clk) begin : cmp
    int    outstanding;
    bit    rd_issue;
    wr_t   w;
    int    a;
    val_t  e;
    if (!reset) begin
      outstanding = n_issued - n_popped;
      rd_issue    = bus.ce0 && !bus.we0;
      if (bus.ce0) ce_count++;
      if (bus.ce0 && bus.we0) begin
        wr_cyc_log.push_back(cyc);
        wr_addr_log.push_back(int'(bus.address0));
        if (exp_wr.size() == 0) begin
          check(1'b0, "unexpected_write", val_t'(bus.address0), val_t'(0));
        end else begin
          w = exp_wr.pop_front();
          check(int'(bus.address0) == w.addr, "wr_addr", val_t'(bus.address0), val_t'(w.addr));
          check(bus.d0 == w.data, "wr_data", val_t'(bus.d0), val_t'(w.data));
        end
      end
      if (exp_rd_addr.size() > 0) begin
        check(rd_issue == (outstanding < FifoDepth), "rd_issue_credit", val_t'(rd_issue),
              val_t'(outstanding < FifoDepth));
        if (outstanding >= FifoDepth) stall_seen++;
        if (rd_issue) begin
          a = exp_rd_addr.pop_front();
          rd_addr_log.push_back(int'(bus.address0));
          check(int'(bus.address0) == a, "rd_addr", val_t'(bus.address0), val_t'(a));
        end
      end else begin
        check(!rd_issue, "rd_issue_idle", val_t'(rd_issue), val_t'(0));
      end
      if (rd_issue) n_issued++;
      if (bus.rd_data_valid && bus.rd_data_ready) begin
        rv_cyc_log.push_back(cyc);
        rv_data_log.push_back(bus.rd_data);
        if (exp_rd.size() == 0) begin
          check(1'b0, "unexpected_rd_data", val_t'(bus.rd_data), val_t'(0));
        end else begin
          e = exp_rd.pop_front();
          check({bus.rd_data_last, bus.rd_data} == e, "rd_word", {bus.rd_data_last, bus.rd_data}, e);
        end
        n_popped++;
      end
    end
  end

  initial begin
    bus.rd_data_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.rd_data_ready = 1'b1;
        1:       bus.rd_data_ready = 1'($urandom_range(0, 1));
        2:       bus.rd_data_ready = (cyc % 3 == 0);
        default: bus.rd_data_ready = 1'b0;
      endcase
    end
  end

  function automatic word_t rand_word();
    word_t w;
    for (int j = 0; j < DataWidth / 32; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic accept_cmd(input bit wr, input int base, input int len, output int t);
    bit got = 1'b0;
    bus.cmd_write = wr;
    bus.cmd_base  = AddressWidth'(base);
    bus.cmd_len   = LenWidth'(len);
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = bus.cmd_ready;
    end
    check(got, "cmd_accept_timeout", val_t'(got), val_t'(1));
    t = cyc;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_load(input int base, input word_t words[$], input bit gaps, output int t);
    int i = 0;
    int guard = 0;
    int len = words.size();
    accept_cmd(1'b1, base, len, t);
    for (int k = 0; k < len; k++) begin
      ref_mem[(base + k) % AddressRange] = words[k];
      exp_wr.push_back('{(base + k) % AddressRange, words[k]});
    end
    while (i < len && guard < 20 * len + 50) begin
      bus.wr_data_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.wr_data       = words[i];
      @(negedge clk);
      if (bus.wr_data_valid && bus.wr_data_ready) i++;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.wr_data_valid = 1'b0;
    bus.wr_data       = '0;
    check(i == len, "load_stalled", val_t'(i), val_t'(len));
  endtask

  task automatic do_scan(input int base, input int len, output int t);
    accept_cmd(1'b0, base, len, t);
    for (int k = 0; k < len; k++) begin
      exp_rd_addr.push_back((base + k) % AddressRange);
      exp_rd.push_back({k == len - 1, ref_mem[(base + k) % AddressRange]});
    end
  endtask

  task automatic wait_done(input int bound, output int dc, output bit rdy);
    dc  = -1;
    rdy = 1'b0;
    for (int k = 0; k < bound && dc < 0; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dc  = cyc;
        rdy = bus.cmd_ready;
      end
    end
    check(dc >= 0, "done_timeout", val_t'(dc >= 0), val_t'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_complete(input string tag);
    check(exp_wr.size() == 0 && exp_rd.size() == 0 && exp_rd_addr.size() == 0, tag,
          val_t'(exp_wr.size() + exp_rd.size() + exp_rd_addr.size()), val_t'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [9:0] act;
    act = {bus.cmd_ready, bus.wr_data_ready, bus.rd_data_valid, |bus.rd_data, bus.rd_data_last,
           bus.done, bus.ce0, bus.we0, |bus.address0, |bus.d0};
    check(act == 10'b10_0000_0000, tag, val_t'(act), val_t'(10'b10_0000_0000));
  endtask

  initial begin
    word_t words[$];
    int    t, dc, bad, ce_before, ndone;
    bit    rdy;

    bus.cmd_valid     = 1'b0;
    bus.cmd_write     = 1'b0;
    bus.cmd_base      = '0;
    bus.cmd_len       = '0;
    bus.wr_data_valid = 1'b0;
    bus.wr_data       = '0;
    reset             = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    reset = 1'b0;

    // Whole-buffer load from a non-zero base (wraps once), then whole-buffer scan.
    rdy_mode = 0;
    words.delete();
    for (int i = 0; i < AddressRange; i++) words.push_back(rand_word());
    do_load(7, words, 1'b0, t);
    wait_done(50, dc, rdy);
    check_complete("full_load_complete");
    bad = 0;
    for (int a = 0; a < AddressRange; a++) if (mem[a] != ref_mem[a]) bad++;
    check(bad == 0, "full_load_contents", val_t'(bad), val_t'(0));
    rdy_mode = 1;
    do_scan(1000, AddressRange, t);
    wait_done(20 * AddressRange, dc, rdy);
    check_complete("full_scan_complete");

    // Load 0xA0..0xA3 at address 0 with continuous valid.
    rdy_mode = 0;
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back(DataWidth'(160 + i));
    wr_cyc_log.delete();
    wr_addr_log.delete();
    do_load(0, words, 1'b0, t);
    wait_done(50, dc, rdy);
    check(wr_cyc_log.size() == 4, "load4_count", val_t'(wr_cyc_log.size()), val_t'(4));
    for (int i = 0; i < 4; i++) begin
      check(wr_cyc_log[i] == t + 1 + i, "load4_cycle", val_t'(wr_cyc_log[i]), val_t'(t + 1 + i));
      check(wr_addr_log[i] == i, "load4_addr", val_t'(wr_addr_log[i]), val_t'(i));
    end
    check(dc == t + 6, "load4_done_cycle", val_t'(dc), val_t'(t + 6));

    // Scan it back with ready held high: fixed latency, back-to-back words.
    rv_cyc_log.delete();
    rv_data_log.delete();
    do_scan(0, 4, t);
    wait_done(60, dc, rdy);
    check_complete("scan4_complete");
    check(rv_cyc_log.size() == 4, "scan4_count", val_t'(rv_cyc_log.size()), val_t'(4));
    for (int i = 0; i < 4; i++) begin
      check(rv_cyc_log[i] == t + 4 + i, "scan4_cycle", val_t'(rv_cyc_log[i]), val_t'(t + 4 + i));
      check(rv_data_log[i] == DataWidth'(160 + i), "scan4_data", val_t'(rv_data_log[i]),
            val_t'(160 + i));
    end
    check(dc == t + 9, "scan4_done_cycle", val_t'(dc), val_t'(t + 9));

    // Address wrap at the top of the buffer, for scan and for load.
    rd_addr_log.delete();
    do_scan(AddressRange - 2, 4, t);
    wait_done(60, dc, rdy);
    check(rd_addr_log.size() == 4, "wrap_scan_count", val_t'(rd_addr_log.size()), val_t'(4));
    for (int i = 0; i < 4; i++) begin
      check(rd_addr_log[i] == (AddressRange - 2 + i) % AddressRange, "wrap_scan_addr",
            val_t'(rd_addr_log[i]), val_t'((AddressRange - 2 + i) % AddressRange));
    end
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back(rand_word());
    wr_addr_log.delete();
    do_load(AddressRange - 2, words, 1'b1, t);
    wait_done(50, dc, rdy);
    for (int i = 0; i < 4; i++) begin
      check(wr_addr_log[i] == (AddressRange - 2 + i) % AddressRange, "wrap_load_addr",
            val_t'(wr_addr_log[i]), val_t'((AddressRange - 2 + i) % AddressRange));
    end
    do_scan(AddressRange - 2, 4, t);
    wait_done(60, dc, rdy);
    check_complete("wrap_rescan_complete");

    // Sparse ready: credits run out and issue must stall, nothing lost.
    rdy_mode   = 2;
    stall_seen = 0;
    rv_data_log.delete();
    do_scan(100, 8, t);
    wait_done(200, dc, rdy);
    check_complete("sparse_scan_complete");
    check(rv_data_log.size() == 8, "sparse_scan_count", val_t'(rv_data_log.size()), val_t'(8));
    check(stall_seen > 0, "sparse_scan_stalled", val_t'(stall_seen), val_t'(1));

    // Zero-length command.
    rdy_mode  = 0;
    ce_before = ce_count;
    accept_cmd(1'b0, 5, 0, t);
    wait_done(20, dc, rdy);
    check(ce_count == ce_before, "len0_no_ce0", val_t'(ce_count - ce_before), val_t'(0));
    check(dc == t + 2, "len0_done_cycle", val_t'(dc), val_t'(t + 2));
    check(rdy, "len0_cmd_ready", val_t'(rdy), val_t'(1));

    // Reset while reads are in flight and ready is held low.
    rdy_mode = 3;
    do_scan(0, 8, t);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("reset_mid_scan");
    exp_rd.delete();
    exp_rd_addr.delete();
    n_issued = 0;
    n_popped = 0;
    reset    = 1'b0;
    rdy_mode = 0;
    ndone    = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check(ndone == 0, "reset_no_done", val_t'(ndone), val_t'(0));
    @(posedge clk);
    #1;
    do_scan(0, 4, t);
    wait_done(60, dc, rdy);
    check_complete("post_reset_scan_complete");

    // Random mix of loads and scans.
    for (int n = 0; n < 40; n++) begin
      int base = $urandom_range(0, AddressRange - 1);
      int len  = $urandom_range(0, 40);
      rdy_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        words.delete();
        for (int i = 0; i < len; i++) words.push_back(rand_word());
        do_load(base, words, 1'b1, t);
      end else begin
        do_scan(base, len, t);
      end
      wait_done(20 * len + 60, dc, rdy);
      check_complete("random_cmd_complete");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
